// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master shift engine.
package spi_pkg;

  localparam int LEN_W = 16;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CS_SETUP,
    SHIFT,
    PUSH,
    CS_HOLD
  } spi_state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: toggles sclk every CLK_DIV cycles while enabled and
// emits one-cycle strobes on the clk edge where sclk rises or falls.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          last;

  assign last      = (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = en && last && !sclk;
  assign fall_tick = en && last && sclk;

  // Half-period counter; disabling parks sclk low and restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (last) begin
      cnt  <= '0;
      sclk <= !sclk;
    end else begin
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_engine.sv
// SPI mode-0 master shift engine: pops TX bytes, shifts them out MSB first,
// captures MISO during the read phase and pushes bytes to the RX FIFO.
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int DATA    = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] len,
  input  logic             op,
  input  logic             work,
  output logic             busy,
  input  logic [DATA-1:0]  tx_data,
  output logic             tx_rd,
  input  logic             tx_empty,
  output logic [DATA-1:0]  rx_data,
  output logic             rx_wr,
  input  logic             rx_full,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  localparam int BW = $clog2(DATA);
  localparam int HW = $clog2(CLK_DIV + 1);

  spi_state_t       state, state_nx;
  logic [LEN_W-1:0] bits_left;
  logic             op_q;
  logic             rx_phase;
  logic             fetch_sub;
  logic [DATA-1:0]  sr;
  logic [DATA-1:0]  rx_sr;
  logic [DATA-1:0]  rx_hold;
  logic [BW-1:0]    bit_idx;
  logic [HW-1:0]    cnt;
  logic             rise_tick, fall_tick;
  logic             start, pop_ok, byte_end, cnt_last, cnt_end;

  assign start    = (state == IDLE) && work && (len != '0);
  assign pop_ok   = !tx_empty && ((op_q == OP_WRITE) || !rx_phase);
  assign tx_rd    = (state == FETCH) && !fetch_sub && pop_ok;
  assign byte_end = (bit_idx == BW'(DATA - 1)) || (bits_left == '0);
  assign cnt_last = (cnt == HW'(CLK_DIV - 1));
  assign cnt_end  = (cnt == HW'(CLK_DIV));
  assign busy     = (state != IDLE);
  assign mosi     = ((state == CS_SETUP) || (state == SHIFT)) ? sr[DATA-1] : 1'b0;

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (state == SHIFT),
    .sclk     (sclk),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; cs_n still high in FETCH marks the first byte.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (start) state_nx = FETCH;
      FETCH: begin
        if (fetch_sub || (!pop_ok && (op_q == OP_READ)))
          state_nx = cs_n ? CS_SETUP : SHIFT;
      end
      CS_SETUP: if (cnt_last) state_nx = SHIFT;
      SHIFT: begin
        if (fall_tick && byte_end) begin
          if (rx_phase)              state_nx = PUSH;
          else if (bits_left != '0)  state_nx = FETCH;
          else                       state_nx = CS_HOLD;
        end
      end
      PUSH: begin
        if (!rx_full) state_nx = (bits_left != '0) ? FETCH : CS_HOLD;
      end
      CS_HOLD:  if (cnt_end) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Cycle counter for the chip-select setup and hold windows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (((state == CS_SETUP) || (state == CS_HOLD)) && (state_nx == state))
      cnt <= cnt + HW'(1);
    else
      cnt <= '0;
  end

  // Chip select: drops one cycle into setup, rises CLK_DIV cycles into hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cs_n <= 1'b1;
    else if (state == CS_SETUP)
      cs_n <= 1'b0;
    else if ((state == CS_HOLD) && cnt_last)
      cs_n <= 1'b1;
  end

  // Datapath: transaction latch, byte fetch, shift/capture and RX push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bits_left <= '0;
      op_q      <= OP_WRITE;
      rx_phase  <= 1'b0;
      fetch_sub <= 1'b0;
      sr        <= '0;
      rx_sr     <= '0;
      rx_hold   <= '0;
      bit_idx   <= '0;
      rx_data   <= '0;
      rx_wr     <= 1'b0;
    end else begin
      rx_wr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            bits_left <= len;
            op_q      <= op;
            rx_phase  <= 1'b0;
            fetch_sub <= 1'b0;
          end
        end
        FETCH: begin
          if (fetch_sub) begin
            sr        <= tx_data;
            bit_idx   <= '0;
            fetch_sub <= 1'b0;
          end else if (pop_ok) begin
            fetch_sub <= 1'b1;
          end else if (op_q == OP_READ) begin
            rx_phase  <= 1'b1;
            sr        <= '0;
            bit_idx   <= '0;
          end
        end
        SHIFT: begin
          if (rise_tick) begin
            rx_sr     <= {rx_sr[DATA-2:0], miso};
            bits_left <= bits_left - LEN_W'(1);
          end
          if (fall_tick) begin
            sr      <= {sr[DATA-2:0], 1'b0};
            bit_idx <= bit_idx + BW'(1);
            // Short final byte: shifting left drops stale bits and zero-pads.
            if (byte_end)
              rx_hold <= rx_sr << (BW'(DATA - 1) - bit_idx);
          end
        end
        PUSH: begin
          if (!rx_full) begin
            rx_wr   <= 1'b1;
            rx_data <= rx_hold;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Directed testbench for spi_master_engine with TX FIFO, RX log and MISO models.
module tb_spi_master_engine;
  import spi_pkg::*;

  localparam int DATA    = 8;
  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] len = '0;
  logic        op = 1'b0;
  logic        work = 1'b0;
  logic        busy;
  logic [7:0]  tx_data = '0;
  logic        tx_rd;
  logic        tx_empty;
  logic [7:0]  rx_data;
  logic        rx_wr;
  logic        rx_full = 1'b0;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_master_engine #(
    .DATA   (DATA),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .len     (len),
    .op      (op),
    .work    (work),
    .busy    (busy),
    .tx_data (tx_data),
    .tx_rd   (tx_rd),
    .tx_empty(tx_empty),
    .rx_data (rx_data),
    .rx_wr   (rx_wr),
    .rx_full (rx_full),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso)
  );

  // TX FIFO model: data valid the cycle after tx_rd.
  logic [7:0] tx_mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign tx_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (tx_rd) begin
      tx_data <= tx_mem[rd_ptr % 32];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  // Pop/push counters, RX log and strobe-rule violations.
  int pop_cnt = 0;
  int push_cnt = 0;
  int viol_cnt = 0;
  logic [7:0] rx_log [0:31];
  logic prev_tx_rd = 1'b0;
  logic prev_rx_wr = 1'b0;
  always @(posedge clk) begin
    if (tx_rd) pop_cnt <= pop_cnt + 1;
    if (rx_wr) begin
      rx_log[push_cnt % 32] <= rx_data;
      push_cnt <= push_cnt + 1;
    end
    if ((tx_rd && rx_wr) || (tx_rd && prev_tx_rd) || (rx_wr && prev_rx_wr))
      viol_cnt <= viol_cnt + 1;
    prev_tx_rd <= tx_rd;
    prev_rx_wr <= rx_wr;
  end

  // MOSI capture at each SCLK rise; MISO pattern indexed by rises since rise_base.
  int rise_cnt = 0;
  int rise_base = 0;
  logic [63:0] mosi_sr = '0;
  logic [63:0] miso_pat = '0;
  logic [5:0]  miso_sel;
  always @(posedge sclk) begin
    rise_cnt <= rise_cnt + 1;
    mosi_sr  <= {mosi_sr[62:0], mosi};
  end
  assign miso_sel = 6'(63 - (rise_cnt - rise_base));
  assign miso = miso_pat[miso_sel];

  task automatic push_tx(input logic [7:0] b);
    tx_mem[wr_ptr % 32] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic start_txn(input logic [15:0] l, input logic o);
    @(negedge clk);
    len  = l;
    op   = o;
    work = 1'b1;
    @(negedge clk);
    work = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n  = 0;
    ok = !busy;
    while (!ok && n < 4000) begin
      @(negedge clk);
      ok = !busy;
      n++;
    end
  endtask

  task automatic wait_rises(input int target, output bit ok);
    int n;
    n  = 0;
    ok = (rise_cnt - rise_base) >= target;
    while (!ok && n < 4000) begin
      @(negedge clk);
      ok = (rise_cnt - rise_base) >= target;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, cs_n, sclk, mosi} !== 4'b0100) begin
      failures++;
      $display("FAIL reset_pins actual busy,cs_n,sclk,mosi=%b required=0100", {busy, cs_n, sclk, mosi});
    end
    checks++;
    if ({tx_rd, rx_wr} !== 2'b00) begin
      failures++;
      $display("FAIL reset_strobes actual tx_rd,rx_wr=%b required=00", {tx_rd, rx_wr});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_rx_data actual=%h required=00", rx_data);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_len_zero();
    bit stayed;
    start_txn(16'd0, OP_WRITE);
    stayed = 1'b1;
    repeat (4) begin
      if (busy !== 1'b0 || cs_n !== 1'b1) stayed = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!stayed) begin
      failures++;
      $display("FAIL len_zero_ignored actual busy=%b cs_n=%b required busy=0 cs_n=1", busy, cs_n);
    end
  endtask

  task automatic test_write();
    int p0, q0;
    bit ok;
    p0 = pop_cnt;
    q0 = push_cnt;
    rise_base = rise_cnt;
    push_tx(8'h00); push_tx(8'h19); push_tx(8'h04); push_tx(8'h0f); push_tx(8'ha0);
    start_txn(16'd40, OP_WRITE);
    checks++;
    if ({busy, tx_rd} !== 2'b11) begin
      failures++;
      $display("FAIL write_start actual busy,tx_rd=%b required=11", {busy, tx_rd});
    end
    @(negedge clk);
    checks++;
    if ({tx_rd, cs_n} !== 2'b01) begin
      failures++;
      $display("FAIL write_n1 actual tx_rd,cs_n=%b required=01", {tx_rd, cs_n});
    end
    @(negedge clk);
    checks++;
    if (cs_n !== 1'b1) begin
      failures++;
      $display("FAIL write_cs_n2 actual=%b required=1", cs_n);
    end
    // A second request while busy must be ignored.
    len  = 16'd8;
    op   = OP_READ;
    work = 1'b1;
    @(negedge clk);
    work = 1'b0;
    checks++;
    if (cs_n !== 1'b0) begin
      failures++;
      $display("FAIL write_cs_n3 actual=%b required=0", cs_n);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL write_timeout actual busy=%b required=0", busy);
    end
    checks++;
    if (pop_cnt - p0 != 5) begin
      failures++;
      $display("FAIL write_pops actual=%0d required=5", pop_cnt - p0);
    end
    checks++;
    if (rise_cnt - rise_base != 40) begin
      failures++;
      $display("FAIL write_rises actual=%0d required=40", rise_cnt - rise_base);
    end
    checks++;
    if (mosi_sr[39:0] !== 40'h0019040fa0) begin
      failures++;
      $display("FAIL write_mosi actual=%h required=0019040fa0", mosi_sr[39:0]);
    end
    checks++;
    if (push_cnt != q0 || cs_n !== 1'b1) begin
      failures++;
      $display("FAIL write_end actual pushes=%0d cs_n=%b required pushes=0 cs_n=1", push_cnt - q0, cs_n);
    end
  endtask

  task automatic test_read();
    int p0, q0;
    bit ok;
    p0 = pop_cnt;
    q0 = push_cnt;
    rise_base = rise_cnt;
    miso_pat = {24'h0, 8'h0f, 8'ha0, 24'h0};
    push_tx(8'h00); push_tx(8'h19); push_tx(8'h00);
    start_txn(16'd40, OP_READ);
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL read_timeout actual busy=%b required=0", busy);
    end
    checks++;
    if (pop_cnt - p0 != 3 || push_cnt - q0 != 2) begin
      failures++;
      $display("FAIL read_counts actual pops=%0d pushes=%0d required pops=3 pushes=2", pop_cnt - p0, push_cnt - q0);
    end
    checks++;
    if (rx_log[q0 % 32] !== 8'h0f || rx_log[(q0 + 1) % 32] !== 8'ha0) begin
      failures++;
      $display("FAIL read_rx_data actual=%h,%h required=0f,a0", rx_log[q0 % 32], rx_log[(q0 + 1) % 32]);
    end
    checks++;
    if (mosi_sr[39:0] !== 40'h0019000000) begin
      failures++;
      $display("FAIL read_mosi actual=%h required=0019000000", mosi_sr[39:0]);
    end
  endtask

  task automatic test_tx_empty_stall();
    int p0;
    bit ok, stalled;
    p0 = pop_cnt;
    rise_base = rise_cnt;
    push_tx(8'hc3);
    start_txn(16'd16, OP_WRITE);
    wait_rises(8, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_first_byte_timeout actual rises=%0d required=8", rise_cnt - rise_base);
    end
    repeat (2 * CLK_DIV + 4) @(negedge clk);
    stalled = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (sclk !== 1'b0 || cs_n !== 1'b0 || busy !== 1'b1) stalled = 1'b0;
    end
    checks++;
    if (!stalled || rise_cnt - rise_base != 8) begin
      failures++;
      $display("FAIL stall_hold actual sclk=%b cs_n=%b busy=%b rises=%0d required sclk=0 cs_n=0 busy=1 rises=8",
               sclk, cs_n, busy, rise_cnt - rise_base);
    end
    push_tx(8'h5a);
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_resume_timeout actual busy=%b required=0", busy);
    end
    checks++;
    if (mosi_sr[15:0] !== 16'hc35a || rise_cnt - rise_base != 16 || pop_cnt - p0 != 2) begin
      failures++;
      $display("FAIL stall_resume actual mosi=%h rises=%0d pops=%0d required mosi=c35a rises=16 pops=2",
               mosi_sr[15:0], rise_cnt - rise_base, pop_cnt - p0);
    end
  endtask

  task automatic test_rx_full();
    int q0;
    bit ok, held;
    q0 = push_cnt;
    rise_base = rise_cnt;
    miso_pat = {8'h96, 56'h0};
    rx_full = 1'b1;
    start_txn(16'd8, OP_READ);
    wait_rises(8, ok);
    held = ok;
    repeat (50) begin
      @(negedge clk);
      if (push_cnt != q0 || busy !== 1'b1) held = 1'b0;
    end
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL rx_full_hold actual pushes=%0d busy=%b required pushes=0 busy=1", push_cnt - q0, busy);
    end
    rx_full = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || push_cnt - q0 != 1 || rx_log[q0 % 32] !== 8'h96) begin
      failures++;
      $display("FAIL rx_full_push actual pushes=%0d data=%h required pushes=1 data=96", push_cnt - q0, rx_log[q0 % 32]);
    end
  endtask

  task automatic test_partial();
    int q0;
    bit ok;
    q0 = push_cnt;
    rise_base = rise_cnt;
    miso_pat = '1;
    start_txn(16'd12, OP_READ);
    wait_idle(ok);
    checks++;
    if (!ok || push_cnt - q0 != 2 || rise_cnt - rise_base != 12) begin
      failures++;
      $display("FAIL partial_counts actual pushes=%0d rises=%0d required pushes=2 rises=12", push_cnt - q0, rise_cnt - rise_base);
    end
    checks++;
    if (rx_log[q0 % 32] !== 8'hff || rx_log[(q0 + 1) % 32] !== 8'hf0) begin
      failures++;
      $display("FAIL partial_data actual=%h,%h required=ff,f0", rx_log[q0 % 32], rx_log[(q0 + 1) % 32]);
    end
    miso_pat = '0;
  endtask

  task automatic test_async_reset();
    int p0;
    bit ok;
    p0 = pop_cnt;
    rise_base = rise_cnt;
    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33); push_tx(8'h44); push_tx(8'h55);
    start_txn(16'd40, OP_WRITE);
    wait_rises(20, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL areset_reach_bit20 actual rises=%0d required=20", rise_cnt - rise_base);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({cs_n, sclk, busy} !== 3'b100) begin
      failures++;
      $display("FAIL areset_immediate actual cs_n,sclk,busy=%b required=100", {cs_n, sclk, busy});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    checks++;
    if (pop_cnt - p0 != 3) begin
      failures++;
      $display("FAIL areset_pops actual=%0d required=3", pop_cnt - p0);
    end
    rise_base = rise_cnt;
    start_txn(16'd16, OP_WRITE);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL areset_restart_busy actual=%b required=1", busy);
    end
    wait_idle(ok);
    checks++;
    if (!ok || mosi_sr[15:0] !== 16'h4455 || pop_cnt - p0 != 5 || cs_n !== 1'b1) begin
      failures++;
      $display("FAIL areset_restart actual mosi=%h pops=%0d cs_n=%b required mosi=4455 pops=5 cs_n=1",
               mosi_sr[15:0], pop_cnt - p0, cs_n);
    end
  endtask

  task automatic test_strobe_rules();
    checks++;
    if (viol_cnt != 0) begin
      failures++;
      $display("FAIL strobe_rules actual violations=%0d required=0", viol_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_len_zero();
    test_write();
    test_read();
    test_tx_empty_stall();
    test_rx_full();
    test_partial();
    test_async_reset();
    test_strobe_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_engine.md
# spi_master_engine

SPI master shift engine driven by the command FSM through `len`/`op`/`work`/`busy`. It drains transmit bytes from the TX FIFO, drives the SPI pins in mode 0, and pushes captured bytes into the RX FIFO. It sits directly downstream of the command FSM and its two FIFOs, and directly upstream of the flash pins.

## Interface
- `DATA`, 8: FIFO byte width; the shift register width.
- `CLK_DIV`, 4: SCLK half-period in `clk` cycles, ≥2.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-low reset.
- `len` in 16: transaction length in SCLK bits; sampled with `work`.
- `op` in 1: 1 = write-only, 0 = write-then-read; sampled with `work`.
- `work` in 1: start request; single-cycle pulse accepted only while `busy`=0.
- `busy` out 1: transaction in progress.
- `tx_data` in DATA: TX FIFO read data, valid the cycle after `tx_rd`.
- `tx_rd` out 1: TX FIFO pop, one cycle per byte.
- `tx_empty` in 1: TX FIFO empty.
- `rx_data` out DATA: byte pushed to RX FIFO.
- `rx_wr` out 1: RX FIFO push, one cycle per byte.
- `rx_full` in 1: RX FIFO full.
- `sclk` out 1: SPI clock, idles low.
- `cs_n` out 1: chip select, active low.
- `mosi` out 1: serial out, MSB first.
- `miso` in 1: serial in.

## Operation
- Reset (`rst`=0, immediate): `busy`=0, `tx_rd`=0, `rx_wr`=0, `rx_data`=0, `sclk`=0, `cs_n`=1, `mosi`=0; state IDLE; bit counter and rx-phase flag cleared.
- IDLE: `work`=1 with `len`≠0 latches `len`/`op` and enters FETCH. `work` with `len`=0 is ignored; `busy` stays 0.
- FETCH (each byte boundary):
  - op=1: if `tx_empty`, stall with `sclk` low and `cs_n` unchanged; else pulse `tx_rd` and load `tx_data` next cycle.
  - op=0: while the rx-phase flag is clear and `tx_empty`=0, pop as for op=1. Otherwise set the sticky rx-phase flag and load 0x00.
- CS_SETUP (first byte only): `cs_n`=0 for CLK_DIV cycles before the first SCLK edge.
- SHIFT: `mosi` holds the shift-register MSB. `sclk` rises after CLK_DIV cycles, `miso` is sampled at the rising edge, `sclk` falls after another CLK_DIV cycles, then the register shifts left. The bit counter decrements at each rising edge.
- Byte end (8 bits, or the remaining bits when `len` mod 8 ≠ 0):
  - If the rx-phase flag is set, go to PUSH. A partial final byte is pushed left-aligned and zero-padded. PUSH stalls while `rx_full`; otherwise it pulses `rx_wr` with `rx_data`.
  - Then go to FETCH if bits remain, else CS_HOLD.
- CS_HOLD: after CLK_DIV cycles `cs_n`=1; the next cycle `busy`=0 and state is IDLE.
- Bits transmitted beyond the bytes available in an op=1 transaction: never sent; the engine stalls (no zero fill).
- `work` while `busy`=1 is ignored. `len`/`op` changes mid-transaction have no effect.

## Timing
- Start latency: `work` high at edge N → `busy`=1 and first `tx_rd` at N+1 (if TX non-empty). Data loads at N+2; `cs_n` falls at N+3.
- A byte takes 16·CLK_DIV cycles of SHIFT plus 2 cycles of FETCH when not stalled.
- Inter-byte gap: `sclk` held low during FETCH/PUSH; `cs_n` stays low throughout.
- End: `busy` falls CLK_DIV+1 cycles after the last `sclk` falling edge.
- `tx_rd` and `rx_wr` are never asserted in the same cycle and never last longer than 1 cycle.
- Async reset mid-transaction aborts at once: `cs_n` rises and partial RX bytes are discarded. FIFO contents are untouched.

## Structure
- Package `spi_pkg`:
  - `spi_state_t` enum: IDLE, FETCH, CS_SETUP, SHIFT, PUSH, CS_HOLD.
  - Constants `OP_READ`=1'b0 and `OP_WRITE`=1'b1.
  - `LEN_W`=16.
- Sub-module `spi_clk_gen`: CLK_DIV counter producing one-cycle `rise_tick`/`fall_tick` strobes and `sclk`; enabled only in SHIFT.
- Top holds the FSM, the shift register, the bit counter and the rx-phase flag.

## Test plan
- Write, op=1, `len`=40, TX preloaded 00 19 04 0f a0:
  - 5 `tx_rd` pulses and 40 `sclk` rising edges.
  - MOSI stream is 0x0019040FA0, MSB first.
  - No `rx_wr`; `busy` returns 0 and `cs_n`=1.
- Read, op=0, `len`=40, TX 00 19 00, MISO model returns 0x0F then 0xA0 after bit 24:
  - 3 pops, then 2 pushes of rx_data 0x0F then 0xA0.
  - MOSI bits 25–40 are zero.
- TX empty mid write (op=1, `len`=16, one byte preloaded):
  - After 8 bits `sclk` stays low and `cs_n` stays 0 while `busy`=1.
  - Writing 0x5A resumes the transfer; MOSI shows 0x5A.
- `rx_full` held 50 cycles at the first push (op=0, `len`=8, TX empty):
  - `rx_wr` is delayed until `rx_full`=0, then a single push of the captured byte.
- `len`=12, op=0, TX empty, MISO all ones:
  - Pushes 0xFF then 0xF0; 12 `sclk` edges.
- Async `rst` low during bit 20 of a 40-bit write:
  - Same cycle: `cs_n`=1, `sclk`=0, `busy`=0.
  - After release, a new `work` starts cleanly.
